// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: round-robin N-phase signal controller with gap-extended green and pedestrian walk service
module traffic_phase_ctrl #(
  parameter int NUM_PHASES = 4,
  parameter int TMR_W = 6,
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 12,
  parameter int YELLOW_T = 2,
  parameter int ALLRED_T = 1,
  parameter int PED_T = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic [NUM_PHASES-1:0] demand,
  input  logic [NUM_PHASES-1:0] ped_req,
  output logic [NUM_PHASES-1:0] green,
  output logic [NUM_PHASES-1:0] yellow,
  output logic [NUM_PHASES-1:0] red,
  output logic [NUM_PHASES-1:0] ped_walk,
  output logic [NUM_PHASES-1:0] ped_wait,
  output logic [$clog2(NUM_PHASES)-1:0] active_phase
);
  localparam int PW = $clog2(NUM_PHASES);
  localparam logic [TMR_W:0] MIN_E = (TMR_W+1)'(MIN_GREEN);
  localparam logic [TMR_W:0] MAX_E = (TMR_W+1)'(MAX_GREEN);
  localparam logic [TMR_W:0] YEL_E = (TMR_W+1)'(YELLOW_T);
  localparam logic [TMR_W:0] AR_E = (TMR_W+1)'(ALLRED_T);
  localparam logic [TMR_W:0] PED_E = (TMR_W+1)'(PED_T);

  if (NUM_PHASES < 2 || NUM_PHASES > 8 || MIN_GREEN < 1 || MAX_GREEN < MIN_GREEN ||
      YELLOW_T < 1 || ALLRED_T < 1 || PED_T > MAX_GREEN || MAX_GREEN >= 2**TMR_W ||
      YELLOW_T >= 2**TMR_W || ALLRED_T >= 2**TMR_W || PED_T >= 2**TMR_W) begin : gParamCheck
    $error("traffic_phase_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {ALL_RED, GREEN, YELLOW} stateT;
  stateT state;
  logic [TMR_W-1:0] tmr;
  logic [TMR_W:0] elapsed;
  logic walkGranted;
  logic [NUM_PHASES-1:0] req, activeMask, nextMask;
  logic [PW-1:0] nextPhase, idx;
  logic othersReq, allRedExit, greenExit, yellowExit, walkEnd, grant, transition;

  // first requester after active_phase, wrapping back to active_phase itself last
  always_comb begin
    nextPhase = active_phase;
    idx = active_phase;
    for (int k = NUM_PHASES; k >= 1; k--) begin
      idx = PW'((int'(active_phase) + k) % NUM_PHASES);
      if (req[idx]) nextPhase = idx;
    end
  end

  assign req = demand | ped_wait;
  assign elapsed = {1'b0, tmr} + (TMR_W+1)'(1);
  assign activeMask = NUM_PHASES'(1) << active_phase;
  assign nextMask = NUM_PHASES'(1) << nextPhase;
  assign othersReq = |(req & ~activeMask);
  assign allRedExit = state == ALL_RED && tick && elapsed >= AR_E && |req;
  assign grant = allRedExit && ped_wait[nextPhase];
  assign greenExit = state == GREEN && tick && elapsed >= MIN_E && (!walkGranted || elapsed >= PED_E) &&
                     othersReq && (!demand[active_phase] || elapsed >= MAX_E);
  assign walkEnd = state == GREEN && tick && elapsed >= PED_E;
  assign yellowExit = state == YELLOW && tick && elapsed >= YEL_E;
  assign transition = allRedExit || greenExit || yellowExit;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ALL_RED;
      tmr <= '0;
      red <= '1;
      green <= '0;
      yellow <= '0;
      ped_walk <= '0;
      ped_wait <= '0;
      walkGranted <= 1'b0;
      active_phase <= PW'(NUM_PHASES - 1);
    end else begin
      ped_wait <= (ped_wait | ped_req) & ~(grant ? nextMask : '0);
      tmr <= transition ? '0 : (tick && tmr != '1) ? tmr + TMR_W'(1) : tmr;
      if (allRedExit) begin
        state <= GREEN;
        active_phase <= nextPhase;
        green <= nextMask;
        red <= ~nextMask;
        ped_walk <= grant ? nextMask : '0;
        walkGranted <= grant;
      end else if (greenExit) begin
        state <= YELLOW;
        green <= '0;
        yellow <= activeMask;
        ped_walk <= '0;
      end else if (yellowExit) begin
        state <= ALL_RED;
        yellow <= '0;
        red <= '1;
      end else if (walkEnd) begin
        ped_walk <= '0;
      end
    end
  end
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: directed scenarios plus randomized traffic against a tick-counting reference model
module tb_traffic_phase_ctrl;
  localparam int N = 4;
  localparam int MIN_GREEN = 4, MAX_GREEN = 12, YELLOW_T = 2, ALLRED_T = 1, PED_T = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic tick = 1'b0;
  logic [N-1:0] demand = '0, ped_req = '0;
  logic [N-1:0] green, yellow, red, ped_walk, ped_wait;
  logic [1:0] active_phase;
  int checks = 0, errors = 0;

  traffic_phase_ctrl dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .demand(demand), .ped_req(ped_req),
    .green(green), .yellow(yellow), .red(red), .ped_walk(ped_walk), .ped_wait(ped_wait),
    .active_phase(active_phase)
  );

  always #5 clk = ~clk;

  // reference model: mode 0 all-red, 1 green, 2 yellow; mTicks counts ticks spent in the interval
  int mMode = 0, mTicks = 0, mPhase = N - 1;
  bit mWalk = 0, mGiven = 0;
  logic [N-1:0] mWait = '0;

  always @(posedge clk) begin : model
    int mode, t, ph, e, nxt;
    bit walk, given, others;
    logic [N-1:0] w, rq;
    mode = mMode; t = mTicks; ph = mPhase; walk = mWalk; given = mGiven;
    w = mWait | ped_req;
    rq = demand | mWait;
    if (!reset_n) begin
      mode = 0; t = 0; ph = N - 1; walk = 0; given = 0; w = '0;
    end else if (tick) begin
      e = t + 1;
      t = e > 63 ? 63 : e;
      if (mode == 0 && e >= ALLRED_T && rq != 0) begin
        nxt = -1;
        for (int k = 1; k <= N; k++) if (nxt < 0 && rq[(ph + k) % N]) nxt = (ph + k) % N;
        ph = nxt; mode = 1; t = 0;
        given = mWait[ph]; walk = given;
        if (given) w[ph] = 1'b0;
      end else if (mode == 1) begin
        others = (rq & ~(N'(1) << ph)) != 0;
        if (e >= PED_T) walk = 0;
        if (e >= MIN_GREEN && (!given || e >= PED_T) && others && (!demand[ph] || e >= MAX_GREEN)) begin
          mode = 2; t = 0; walk = 0;
        end
      end else if (mode == 2 && e >= YELLOW_T) begin
        mode = 0; t = 0;
      end
    end
    mMode <= mode; mTicks <= t; mPhase <= ph; mWalk <= walk; mGiven <= given; mWait <= w;
  end

  function automatic logic [21:0] expVec();
    logic [N-1:0] oh;
    oh = N'(1) << mPhase;
    return {mMode == 1 ? oh : 4'h0, mMode == 2 ? oh : 4'h0, mMode == 0 ? 4'hF : ~oh,
            mWalk ? oh : 4'h0, mWait, 2'(mPhase)};
  endfunction

  always @(negedge clk) begin
    checks++;
    if ((green | yellow) !== ~red || $countones(~red) > 1 || (ped_walk & ~green) !== 4'h0) begin
      errors++;
      $display("FAIL invariant t=%0t green=%b yellow=%b red=%b walk=%b", $time, green, yellow, red, ped_walk);
    end
  end

  task automatic step(input bit tk);
    tick = tk;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 0; demand = '0; ped_req = '0;
    step(0);
    reset_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    step(0);
    checks++;
    if ({red, green, yellow, ped_walk, ped_wait, active_phase} !== {4'hF, 16'h0, 2'd3}) begin
      errors++;
      $display("FAIL reset_state got red=%b g=%b y=%b w=%b pw=%b ap=%0d expected red=1111 rest 0 ap=3", red, green, yellow, ped_walk, ped_wait, active_phase);
    end
    for (int i = 0; i < 20; i++) begin
      step(1);
      checks++;
      if (red !== 4'hF || green !== 4'h0 || active_phase !== 2'd3) begin
        errors++;
        $display("FAIL idle_hold cycle %0d got red=%b green=%b ap=%0d expected 1111 0000 3", i, red, green, active_phase);
      end
    end
  endtask

  task automatic test_rest_and_cap();
    demand = 4'b0001;
    step(1);
    checks++;
    if (green !== 4'b0001) begin errors++; $display("FAIL first_green got %b expected 0001", green); end
    for (int i = 0; i < 20; i++) begin
      step(1);
      checks++;
      if (green !== 4'b0001) begin errors++; $display("FAIL green_rest cycle %0d got %b expected 0001", i, green); end
    end
    do_reset();
    demand = 4'b0101;
    step(1);
    checks++;
    if (green !== 4'b0001) begin errors++; $display("FAIL cap_entry got %b expected 0001", green); end
    for (int i = 1; i <= MAX_GREEN + YELLOW_T + ALLRED_T; i++) begin
      logic [11:0] got, exp;
      step(1);
      got = {green, yellow, red};
      exp = i < MAX_GREEN ? {4'b0001, 4'b0000, 4'b1110} :
            i < MAX_GREEN + YELLOW_T ? {4'b0000, 4'b0001, 4'b1110} :
            i < MAX_GREEN + YELLOW_T + ALLRED_T ? {4'b0000, 4'b0000, 4'b1111} :
            {4'b0100, 4'b0000, 4'b1011};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL max_green_seq step %0d got g/y/r=%h expected %h", i, got, exp); end
    end
  endtask

  task automatic test_gap_out();
    demand = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      step(1);
      checks++;
      if (green !== 4'b0100) begin errors++; $display("FAIL gap_hold %0d got %b expected 0100", i, green); end
    end
    demand = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] got, exp;
      step(1);
      got = {green, yellow};
      exp = i < YELLOW_T ? 8'b0000_0100 : i < YELLOW_T + ALLRED_T ? 8'h00 : 8'b1000_0000;
      checks++;
      if (got !== exp) begin errors++; $display("FAIL gap_out step %0d got g/y=%b expected %b", i, got, exp); end
    end
  endtask

  task automatic test_ped();
    int walkCnt, greenCnt;
    bit found;
    do_reset();
    demand = 4'b0001;
    step(1);
    ped_req = 4'b0010;
    step(0);
    ped_req = 4'b0000;
    checks++;
    if (ped_wait !== 4'b0010) begin errors++; $display("FAIL ped_latch got %b expected 0010", ped_wait); end
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1);
      found = green === 4'b0010;
    end
    checks++;
    if (!found || ped_walk !== 4'b0010 || ped_wait !== 4'b0000) begin
      errors++;
      $display("FAIL ped_grant found=%0d walk=%b wait=%b expected 1 0010 0000", found, ped_walk, ped_wait);
    end
    walkCnt = int'(ped_walk[1]); greenCnt = int'(green[1]);
    for (int i = 0; i < 9; i++) begin
      step(1);
      walkCnt += int'(ped_walk[1]); greenCnt += int'(green[1]);
    end
    checks++;
    if (walkCnt != PED_T || greenCnt != MIN_GREEN) begin
      errors++;
      $display("FAIL ped_timing walk=%0d green=%0d expected %0d %0d", walkCnt, greenCnt, PED_T, MIN_GREEN);
    end
  endtask

  task automatic test_ped_hold();
    bit found;
    do_reset();
    demand = 4'b0001;
    step(1);
    ped_req = 4'b0010;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1);
      found = green === 4'b0010;
    end
    checks++;
    if (!found || ped_wait[1] !== 1'b0 || ped_walk !== 4'b0010) begin
      errors++;
      $display("FAIL hold_grant found=%0d wait=%b walk=%b expected 1 x0xx 0010", found, ped_wait, ped_walk);
    end
    step(1);
    ped_req = 4'b0000;
    checks++;
    if (ped_wait !== 4'b0010) begin errors++; $display("FAIL hold_relatch got %b expected 0010", ped_wait); end
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1);
      found = yellow === 4'b0010;
    end
    checks++;
    if (!found || ped_wait[1] !== 1'b1) begin errors++; $display("FAIL hold_after_yellow found=%0d wait=%b expected 1 xx1x", found, ped_wait); end
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      step(1);
      found = green === 4'b0010;
    end
    checks++;
    if (!found || ped_walk !== 4'b0010) begin errors++; $display("FAIL hold_reserve found=%0d walk=%b expected 1 0010", found, ped_walk); end
  endtask

  task automatic test_reset_mid();
    bit found;
    do_reset();
    demand = 4'b0100;
    step(1);
    checks++;
    if (green !== 4'b0100) begin errors++; $display("FAIL mid_green got %b expected 0100", green); end
    ped_req = 4'b1000;
    demand = 4'b0000;
    step(1);
    ped_req = 4'b0000;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1);
      found = yellow === 4'b0100;
    end
    checks++;
    if (!found || ped_wait !== 4'b1000) begin errors++; $display("FAIL mid_yellow found=%0d wait=%b expected 1 1000", found, ped_wait); end
    reset_n = 0;
    step(0);
    reset_n = 1;
    checks++;
    if ({red, yellow, green, ped_wait, active_phase} !== {4'hF, 12'h0, 2'd3}) begin
      errors++;
      $display("FAIL mid_reset got red=%b y=%b g=%b wait=%b ap=%0d expected 1111 0 0 0 3", red, yellow, green, ped_wait, active_phase);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) demand = 4'($urandom);
      ped_req = $urandom_range(0, 15) == 0 ? 4'($urandom) : 4'h0;
      reset_n = $urandom_range(0, 199) != 0;
      step($urandom_range(0, 1) == 1);
      checks++;
      if ({green, yellow, red, ped_walk, ped_wait, active_phase} !== expVec()) begin
        errors++;
        $display("FAIL random cycle %0d got %h expected %h", i, {green, yellow, red, ped_walk, ped_wait, active_phase}, expVec());
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_rest_and_cap();
    test_gap_out();
    test_ped();
    test_ped_hold();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
- Parametrised N-phase intersection controller; successor to the two-road main/side light controller.
- Serves NUM_PHASES conflicting approaches round-robin, skipping phases with no request.
- Green timing adapts to detector demand: minimum green, gap extension up to a maximum green, then yellow, then all-red clearance.
- Pedestrian requests are latched per phase and served as a walk interval at the start of that phase's green. Timing advances on an external tick pulse from the shared prescaler.

Parameters:
- NUM_PHASES, 4, number of approaches (2..8)
- TMR_W, 6, timer width in ticks
- MIN_GREEN, 4, minimum green ticks (>=1)
- MAX_GREEN, 12, green cap under continuous own demand (>=MIN_GREEN)
- YELLOW_T, 2, yellow ticks (>=1)
- ALLRED_T, 1, all-red clearance ticks (>=1)
- PED_T, 3, walk ticks (<=MAX_GREEN)

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- tick  in  1  single-cycle timing pulse; timers advance only when high
- demand  in  NUM_PHASES  vehicle presence per phase (level)
- ped_req  in  NUM_PHASES  pedestrian button per phase (level or pulse)
- green  out  NUM_PHASES  green per phase
- yellow  out  NUM_PHASES  yellow per phase
- red  out  NUM_PHASES  red per phase
- ped_walk  out  NUM_PHASES  walk lamp per phase
- ped_wait  out  NUM_PHASES  latched, unserved ped requests
- active_phase  out  $clog2(NUM_PHASES)  phase last or currently served

Behaviour:
- Reset is synchronous, sampled on the clk rising edge when reset_n=0:
  - state=ALL_RED, tmr=0, red=all 1s, green/yellow/ped_walk/ped_wait=0.
  - active_phase=NUM_PHASES-1, so phase 0 is searched first.
- Reset mid-operation forces these values on the next edge regardless of state.
- All outputs are registered. Every phase not in GREEN/YELLOW shows red. At most one phase is non-red at any time.
- Timer:
  - tmr clears on each state entry.
  - On a tick cycle with no transition, tmr increments, saturating at 2^TMR_W-1.
  - "Elapsed" means tmr+1, evaluated on the tick cycle.
- A request for phase i is demand[i] | ped_wait[i]. The "others" term excludes active_phase.
- ALL_RED:
  - Exit on a tick when elapsed>=ALLRED_T and any request exists.
  - The next phase is the first requesting phase searching active_phase+1, +2, … with wrap-around. It may be active_phase itself if it is the only requester.
  - Exit loads active_phase and enters GREEN. With no requests, ALL_RED holds indefinitely.
- GREEN entry:
  - If ped_wait[p] is set, ped_walk[p] rises with green[p] and ped_wait[p] clears.
  - Walk lasts exactly PED_T ticks, then ped_walk drops while green continues.
- GREEN to YELLOW happens on a tick when all of the following hold:
  - elapsed>=MIN_GREEN
  - the walk is complete (elapsed>=PED_T if walk was granted)
  - another phase has a request
  - demand[p]=0 OR elapsed>=MAX_GREEN
- If no other phase has a request, green rests indefinitely, even past MAX_GREEN.
- YELLOW goes to ALL_RED on a tick when elapsed>=YELLOW_T.
- Ped latch rules:
  - ped_req[i]=1 sets ped_wait[i] on the next edge.
  - Walk grant clears it. If set and clear occur in the same cycle, clear wins and the request is considered served.
  - A press on the active phase after walk grant stays latched for its next service.
- tick high in consecutive cycles is legal; each high cycle counts as one tick.
- Latency: an output change appears on the clk edge following the qualifying tick cycle.
- Sizing: MAX_GREEN, YELLOW_T, ALLRED_T and PED_T must each be < 2^TMR_W. A parameter violation is a static elaboration error.

Test Plan:
1. Reset, then demand=0000, ped_req=0000, 20 ticks -> red=1111 throughout, active_phase=3, no green.
2. demand=0001 from reset -> green[0] after the first tick (ALLRED_T=1); rests in green indefinitely. Then demand=0101 with phase 0 demand held -> green[0] total 12 ticks, yellow[0] 2 ticks, red=1111 for 1 tick, then green[2]; phases 1 and 3 skipped.
3. Phase 2 green at elapsed 5, demand[2] drops, demand[3]=1 -> yellow[2] on the next tick, then all-red, then green[3].
4. ped_req[1] pulsed one cycle while phase 0 green -> ped_wait=0010. When phase 1 is served: green[1] and ped_walk[1] rise together, ped_wait=0000. Walk lasts 3 ticks. Green holds at least 4 ticks even with demand[1]=0.
5. ped_req[1] held high across the walk-grant cycle -> ped_wait[1]=0 at grant, then 1 on the next edge. A re-press during green[1] keeps ped_wait[1]=1 after yellow, so phase 1 is re-served on the next round.
6. reset_n low for one cycle during yellow[2] -> next edge red=1111, yellow=0000, ped_wait=0000, active_phase=3. Assert the one-hot non-red invariant on every cycle of all tests.
